motor_ramp_ctrl: RTL
====================

// Module: motor_ramp_ctrl
// PURPOSE
//  Parametrised DC-motor driver for H-bridge (IN1/IN2 + PWM enable). Adds over the
//  single-speed fire-stop driver: PWM speed control, soft-start/stop ramp, bidirectional
//  run with dead-time on reversal, and latched fire fault needing explicit clear.
//  Sits between the plant control logic and the H-bridge pins; fire sensor wired directly.
// PARAMETERS
//  PWM_W     8     duty/PWM counter width; duty range 0..2^PWM_W-1
//  RAMP_DIV  1000  clk cycles per duty step of ramp (>=1)
//  DEAD_CYC  50    clk cycles both bridge inputs held low on direction change (>=1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  fire_n     in   1      fire sensor, async; 0 = fire detected
//  enable     in   1      run request; 0 = ramp down to stop
//  dir_req    in   1      0 = forward, 1 = reverse
//  speed_req  in   PWM_W  target duty
//  fault_clr  in   1      one-cycle pulse, clears latched fault
//  IN1        out  1      bridge input 1
//  IN2        out  1      bridge input 2
//  pwm_en     out  1      bridge enable (PWM)
//  fault      out  1      latched fire fault
//  duty_cur   out  PWM_W  current ramped duty
// BEHAVIOUR
//  Reset: IN1=IN2=pwm_en=fault=0, duty_cur=0, dir_cur=0, state IDLE, all counters 0.
//  fire_n: 2-flop synchroniser, no debounce. fire_s==0 -> FAULT next clk; outputs low
//   <=3 clk after fire_n falls. Overrides every other input in every state.
//  target = (enable && dir_req==dir_cur) ? speed_req : 0.
//  Ramp: tick every RAMP_DIV clks (free-running divider); on tick duty_cur moves 1 LSB
//   toward target, no overshoot; no change when equal. speed_req changes mid-ramp
//   redirect the ramp on the next tick.
//  FSM states IDLE, RUN, DEAD, FAULT:
//   IDLE : duty_cur==0; target!=0 -> RUN; dir_req!=dir_cur -> DEAD.
//   RUN  : ramp active; duty_cur==0 && target==0 -> IDLE (or DEAD if dir_req!=dir_cur).
//   DEAD : IN1=IN2=0 for exactly DEAD_CYC clks; then dir_cur<=dir_req -> IDLE.
//          dir_req toggling back during DEAD does not abort; re-evaluated in IDLE.
//   FAULT: IN1=IN2=pwm_en=0, duty_cur forced 0, fault=1; exit to IDLE only on
//          fault_clr==1 with fire_s==1. fault_clr while fire_s==0 is ignored.
//  Bridge: duty_cur!=0 in RUN -> dir_cur 0: IN1=1,IN2=0; dir_cur 1: IN1=0,IN2=1.
//   Otherwise IN1=IN2=0 (coast). IN1 and IN2 never both 1. All outputs registered.
//  PWM: counter 0..2^PWM_W-2 wrapping (period 2^PWM_W-1 clks); pwm_en = cnt < duty_act.
//   duty_act shadows duty_cur, loaded only when cnt==0 (glitch-free); duty max = 100%.
//   FAULT clears duty_act immediately (not at period boundary).
//  Reverse while running: target forced 0 -> ramp down -> DEAD -> ramp up new dir.
// STRUCTURE
//  Package motor_pkg: state encoding (IDLE/RUN/DEAD/FAULT), DIR_FWD/DIR_REV constants.
//  Sub-module motor_pwm_gen (PWM_W): counter, duty_act shadow, compare, sync clear input.
//  Top holds synchroniser, ramp divider, dead-time counter, FSM, bridge output regs.
// TESTING (bench params PWM_W=4, RAMP_DIV=4, DEAD_CYC=3)
//  1 Reset release, enable=1, speed_req=15, dir=0 -> duty_cur +1 every 4 clk,
//    reaches 15 after 60 clk; IN1=1,IN2=0; pwm_en constant 1 at 15.
//  2 Duty 5 steady -> pwm_en high 5 of every 15 clk, edges only at period boundary.
//  3 Running duty 8, dir_req 0->1 -> ramp to 0 in 32 clk, IN1=IN2=0 exactly 3 clk,
//    then IN2=1, ramp up to 8.
//  4 fire_n low at duty 12 -> IN1=IN2=pwm_en=0, fault=1 within 3 clk; fault_clr
//    while fire_n=0 ignored; fire_n=1 then fault_clr -> IDLE, soft restart from 0.
//  5 enable drops mid-ramp at duty 6 -> ramps down to 0, IDLE, dir unchanged.
//  6 Assert rst_n low mid-DEAD and mid-RUN -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types for the H-bridge motor driver: FSM states, direction codes and
// the bridge-input decode used by the top level.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD,
    ST_FAULT
  } motor_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Returns {IN1, IN2}; the two inputs are never driven high together.
  function automatic logic [1:0] bridge_drive(input logic i_active, input logic i_dir);
    logic [1:0] w_pins;
    w_pins = 2'b00;
    if (i_active) begin
      w_pins = (i_dir == DIR_FWD) ? 2'b10 : 2'b01;
    end
    return w_pins;
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// PWM generator: free-running counter of period 2^PWM_W-1, duty shadowed at the
// period boundary so the output never glitches; i_clr drops the output at once.
module motor_pwm_gen #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_pwm
);

  // Counter stops one short of all-ones so that duty == all-ones means 100 %.
  localparam logic [PWM_W-1:0] CNT_LAST = ~PWM_W'(1);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_act;
  logic [PWM_W-1:0] w_act;
  logic             r_pwm;

  always_comb begin
    w_act = (r_cnt == '0) ? i_duty : r_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_act <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PWM_W'(1);
      if (i_clr) begin
        r_act <= '0;
        r_pwm <= 1'b0;
      end else begin
        r_act <= w_act;
        r_pwm <= (r_cnt < w_act);
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// DC-motor H-bridge driver: soft-start/stop duty ramp, dead-time on reversal,
// PWM enable and a latched fire fault that needs an explicit clear.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned RAMP_DIV = 1000,
  parameter int unsigned DEAD_CYC = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fire_n,
  input  logic             enable,
  input  logic             dir_req,
  input  logic [PWM_W-1:0] speed_req,
  input  logic             fault_clr,
  output logic             IN1,
  output logic             IN2,
  output logic             pwm_en,
  output logic             fault,
  output logic [PWM_W-1:0] duty_cur
);

  localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  motor_state_e      r_state;
  motor_state_e      w_state_nxt;
  logic              r_fire_meta;
  logic              r_fire_s;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  logic [PWM_W-1:0]  r_duty;
  logic [PWM_W-1:0]  w_duty_nxt;
  logic [PWM_W-1:0]  w_target;
  logic              r_dir;
  logic              w_dir_nxt;
  logic [DEAD_W-1:0] r_dead;
  logic [DEAD_W-1:0] w_dead_nxt;
  logic [1:0]        w_bridge;
  logic              w_pwm_clr;
  logic              r_in1;
  logic              r_in2;
  logic              r_fault;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_target    = (enable && (dir_req == r_dir)) ? speed_req : '0;
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = r_dead;

    if (!r_fire_s) begin
      w_state_nxt = ST_FAULT;
      w_duty_nxt  = '0;
      w_dead_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_target != '0) begin
            w_state_nxt = ST_RUN;
          end else if (dir_req != r_dir) begin
            w_state_nxt = ST_DEAD;
          end
        end
        ST_RUN: begin
          if ((r_duty == '0) && (w_target == '0)) begin
            w_state_nxt = (dir_req != r_dir) ? ST_DEAD : ST_IDLE;
          end else if (w_tick) begin
            if (r_duty < w_target) begin
              w_duty_nxt = r_duty + PWM_W'(1);
            end else if (r_duty > w_target) begin
              w_duty_nxt = r_duty - PWM_W'(1);
            end
          end
        end
        ST_DEAD: begin
          // Direction is latched from whatever dir_req shows at the end of the gap.
          if (r_dead == DEAD_LAST) begin
            w_dead_nxt  = '0;
            w_dir_nxt   = dir_req;
            w_state_nxt = ST_IDLE;
          end else begin
            w_dead_nxt = r_dead + DEAD_W'(1);
          end
        end
        ST_FAULT: begin
          w_duty_nxt = '0;
          if (fault_clr) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    w_bridge  = bridge_drive((w_state_nxt == ST_RUN) && (w_duty_nxt != '0), w_dir_nxt);
    w_pwm_clr = (w_state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser idles at "no fire" so reset release does not trip a fault.
      r_fire_meta <= 1'b1;
      r_fire_s    <= 1'b1;
      r_div       <= '0;
      r_duty      <= '0;
      r_dir       <= DIR_FWD;
      r_dead      <= '0;
      r_in1       <= 1'b0;
      r_in2       <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_fire_meta <= fire_n;
      r_fire_s    <= r_fire_meta;
      r_div       <= w_tick ? '0 : r_div + DIV_W'(1);
      r_duty      <= w_duty_nxt;
      r_dir       <= w_dir_nxt;
      r_dead      <= w_dead_nxt;
      r_in1       <= w_bridge[1];
      r_in2       <= w_bridge[0];
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  motor_pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_pwm_clr),
    .i_duty(r_duty),
    .o_pwm (pwm_en)
  );

  assign IN1      = r_in1;
  assign IN2      = r_in2;
  assign fault    = r_fault;
  assign duty_cur = r_duty;

endmodule
